// File: rtl/zero_cross_div_65s_34ns_32_seq.sv
// Sequential radix-2 restoring divider: signed dividend / unsigned divisor -> signed quotient and remainder.
// Fixed latency for every operand; results saturate on quotient overflow or a zero divisor.
module zero_cross_div_65s_34ns_32_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 65,
    parameter int din1_WIDTH = 34,
    parameter int dout_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH:0]   rem,
    output logic                  div_zero,
    output logic                  ovf
);

    localparam int REM_W = din1_WIDTH + 1;
    localparam int CNT_W = $clog2(din0_WIDTH + 1);

    // Largest quotient magnitudes representable for negative and non-negative results.
    localparam logic [din0_WIDTH-1:0] NEG_LIM =
        {{(din0_WIDTH-dout_WIDTH){1'b0}}, 1'b1, {(dout_WIDTH-1){1'b0}}};
    localparam logic [din0_WIDTH-1:0] POS_LIM = NEG_LIM - din0_WIDTH'(1);
    localparam logic [dout_WIDTH-1:0] Q_MIN   = {1'b1, {(dout_WIDTH-1){1'b0}}};
    localparam logic [dout_WIDTH-1:0] Q_MAX   = {1'b0, {(dout_WIDTH-1){1'b1}}};

    if (ID < 0) begin : g_id_tag
    end

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

    state_t state_q, state_d;

    logic [din0_WIDTH-1:0] dvd_q, dvd_d;
    logic [din1_WIDTH-1:0] dsr_q, dsr_d;
    logic [REM_W-1:0]      part_q, part_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  done_q, done_d;
    logic [dout_WIDTH-1:0] dout_q, dout_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic                  dz_q, dz_d;
    logic                  ovf_q, ovf_d;

    logic do_load, do_prep, do_iter, do_fix;

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_PREP;
            S_PREP:  state_d = S_ITER;
            S_ITER:  if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs and datapath controls
    always_comb begin
        ready   = 1'b0;
        do_load = 1'b0;
        do_prep = 1'b0;
        do_iter = 1'b0;
        do_fix  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready   = 1'b1;
                do_load = start;
            end
            S_PREP:  do_prep = 1'b1;
            S_ITER:  do_iter = 1'b1;
            S_FIX:   do_fix  = 1'b1;
            default: ;
        endcase
    end

    logic [REM_W-1:0] part_shift;
    logic [REM_W-1:0] part_sub;
    logic             take;
    logic             is_dz;
    logic             q_over;
    logic             sat;

    always_comb begin
        part_shift = {part_q[REM_W-2:0], dvd_q[din0_WIDTH-1]};
        part_sub   = part_shift - {1'b0, dsr_q};
        take       = (part_shift >= {1'b0, dsr_q});
        is_dz      = (dsr_q == '0);
        // After the last iteration dvd_q holds the unsigned quotient magnitude.
        q_over     = neg_q ? (dvd_q > NEG_LIM) : (dvd_q > POS_LIM);
        sat        = is_dz | q_over;

        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        part_d = part_q;
        cnt_d  = cnt_q;
        neg_d  = neg_q;
        done_d = do_fix;
        dout_d = dout_q;
        rem_d  = rem_q;
        dz_d   = dz_q;
        ovf_d  = ovf_q;

        if (do_load) begin
            dvd_d = din0;
            dsr_d = din1;
        end
        if (do_prep) begin
            neg_d  = dvd_q[din0_WIDTH-1];
            dvd_d  = dvd_q[din0_WIDTH-1] ? -dvd_q : dvd_q;
            part_d = '0;
            cnt_d  = CNT_W'(din0_WIDTH);
        end
        if (do_iter) begin
            part_d = take ? part_sub : part_shift;
            dvd_d  = {dvd_q[din0_WIDTH-2:0], take};
            cnt_d  = cnt_q - CNT_W'(1);
        end
        if (do_fix) begin
            dz_d  = is_dz;
            ovf_d = q_over & ~is_dz;
            if (sat) begin
                dout_d = neg_q ? Q_MIN : Q_MAX;
                rem_d  = '0;
            end else begin
                dout_d = neg_q ? -dvd_q[dout_WIDTH-1:0] : dvd_q[dout_WIDTH-1:0];
                rem_d  = neg_q ? -part_q : part_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dvd_q  <= '0;
            dsr_q  <= '0;
            part_q <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            done_q <= 1'b0;
            dout_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (ce) begin
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            part_q <= part_d;
            cnt_q  <= cnt_d;
            neg_q  <= neg_d;
            done_q <= done_d;
            dout_q <= dout_d;
            rem_q  <= rem_d;
            dz_q   <= dz_d;
            ovf_q  <= ovf_d;
        end
    end

    assign done     = done_q;
    assign dout     = dout_q;
    assign rem      = rem_q;
    assign div_zero = dz_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_zero_cross_div_65s_34ns_32_seq.sv
// Directed bench for the sequential 65s/34u divider: results, flags, latency, stalls and reset.
// A short randomized tail checks results against the language's own signed division.
module tb_zero_cross_div_65s_34ns_32_seq;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        start;
    logic [64:0] din0;
    logic [33:0] din1;
    logic        ready;
    logic        done;
    logic [31:0] dout;
    logic [34:0] rem;
    logic        div_zero;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] QMAX = 32'h7FFF_FFFF;
    localparam logic [31:0] QMIN = 32'h8000_0000;

    zero_cross_div_65s_34ns_32_seq #(
        .ID        (1),
        .din0_WIDTH(65),
        .din1_WIDTH(34),
        .dout_WIDTH(32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .start   (start),
        .din0    (din0),
        .din1    (din1),
        .ready   (ready),
        .done    (done),
        .dout    (dout),
        .rem     (rem),
        .div_zero(div_zero),
        .ovf     (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_div(input string tag, input logic [64:0] a, input logic [33:0] b,
                           input logic [31:0] eq, input logic [34:0] er,
                           input logic edz, input logic eovf,
                           input int stall_at, input bit poke);
        int lat;
        int exp_lat;
        exp_lat = (stall_at >= 0) ? 77 : 67;
        check_eq({tag, "_rdy"}, ready, 1'b1);
        din0  = a;
        din1  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        din0  = 65'h1_2345_6789_ABCD_EF01;
        din1  = 34'h2_0000_0003;
        lat   = 0;
        while (lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
            if (lat == stall_at) ce = 1'b0;
            if (stall_at >= 0 && lat == stall_at + 10) ce = 1'b1;
            if (poke && lat == 5) begin
                start = 1'b1;
                din0  = 65'd1;
                din1  = 34'd1;
            end
            if (poke && lat == 6) start = 1'b0;
        end
        $display("xfer %s din0=%0h din1=%0h dout=%0h rem=%0h dz=%0b ovf=%0b lat=%0d",
                 tag, a, b, dout, rem, div_zero, ovf, lat);
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_q"}, dout, eq);
        check_eq({tag, "_rem"}, rem, er);
        check_eq({tag, "_dz"}, div_zero, edz);
        check_eq({tag, "_ovf"}, ovf, eovf);
        check_eq({tag, "_rdy_at_done"}, ready, 1'b1);
        if (stall_at >= 0) begin
            ce = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check_eq({tag, "_done_hold"}, done, 1'b1);
            check_eq({tag, "_q_hold"}, dout, eq);
            ce = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq({tag, "_done_pulse"}, done, 1'b0);
    endtask

    logic [63:0]        r64;
    logic [64:0]        ra;
    logic [33:0]        rb;
    logic signed [65:0] sa, sb, sq, sr;
    logic [31:0]        req;
    logic [34:0]        rer;
    logic               rdz, rovf;

    initial begin
        reset = 1'b0;
        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        #12;
        check_eq("rst_ready", ready, 1'b1);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_dout", dout, 32'd0);
        check_eq("rst_rem", rem, 35'd0);
        check_eq("rst_dz", div_zero, 1'b0);
        check_eq("rst_ovf", ovf, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_div("p100_7",   65'd100,                34'd7,  32'd14,          35'd2,            1'b0, 1'b0, -1, 1'b0);
        run_div("m100_7",   -65'sd100,              34'd7,  32'hFFFF_FFF2,   35'h7_FFFF_FFFE,  1'b0, 1'b0, -1, 1'b0);
        run_div("m7_7",     -65'sd7,                34'd7,  32'hFFFF_FFFF,   35'd0,            1'b0, 1'b0, -1, 1'b0);
        run_div("roundtrip",-65'sd123456789000,     34'd1000, 32'hF8A4_32EB, 35'd0,            1'b0, 1'b0, -1, 1'b0);
        run_div("pos_sat",  65'h100_0000_0000,      34'd1,  QMAX,            35'd0,            1'b0, 1'b1, -1, 1'b0);
        run_div("clean1",   65'd100,                34'd7,  32'd14,          35'd2,            1'b0, 1'b0, -1, 1'b0);
        run_div("neg_sat",  65'h1_0000_0000_0000_0000, 34'd3, QMIN,          35'd0,            1'b0, 1'b1, -1, 1'b0);
        run_div("min_ok",   -65'sd2147483648,       34'd1,  QMIN,            35'd0,            1'b0, 1'b0, -1, 1'b0);
        run_div("max_ovf",  65'd2147483648,         34'd1,  QMAX,            35'd0,            1'b0, 1'b1, -1, 1'b0);
        run_div("zero_num", 65'd0,                  34'd5,  32'd0,           35'd0,            1'b0, 1'b0, -1, 1'b0);
        run_div("wide",     65'hC_0000_0004,        34'h3_FFFF_FFFF, 32'd3,  35'd7,            1'b0, 1'b0, -1, 1'b0);
        run_div("wide_neg", -65'shC_0000_0004,      34'h3_FFFF_FFFF, 32'hFFFF_FFFD, 35'h7_FFFF_FFF9, 1'b0, 1'b0, -1, 1'b0);
        run_div("div0",     -65'sd5,                34'd0,  QMIN,            35'd0,            1'b1, 1'b0, -1, 1'b0);

        // Reset in the middle of an operation clears the held div0 result at once.
        din0  = 65'd100;
        din1  = 34'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (31) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_eq("arst_dout", dout, 32'd0);
        check_eq("arst_dz", div_zero, 1'b0);
        check_eq("arst_rem", rem, 35'd0);
        check_eq("arst_done", done, 1'b0);
        check_eq("arst_ready", ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_div("post_rst", 65'd100, 34'd7, 32'd14, 35'd2, 1'b0, 1'b0, -1, 1'b0);

        run_div("stall_poke", 65'd100, 34'd7, 32'd14, 35'd2, 1'b0, 1'b0, 30, 1'b1);

        for (int i = 0; i < 12; i++) begin
            r64 = {$urandom(), $urandom()};
            r64 = r64 >> $urandom_range(0, 40);
            ra  = {1'b0, r64};
            if ($urandom_range(0, 1) == 1) ra = -ra;
            rb  = {2'($urandom_range(0, 3)), $urandom()};
            if (i == 3) rb = '0;
            sa  = $signed({ra[64], ra});
            sb  = $signed({32'd0, rb});
            if (rb == '0) begin
                rdz  = 1'b1;
                rovf = 1'b0;
                req  = ra[64] ? QMIN : QMAX;
                rer  = '0;
            end else begin
                sq   = sa / sb;
                sr   = sa % sb;
                rdz  = 1'b0;
                rovf = (sq > 66'sd2147483647) || (sq < -66'sd2147483648);
                req  = rovf ? (ra[64] ? QMIN : QMAX) : sq[31:0];
                rer  = rovf ? 35'd0 : sr[34:0];
            end
            run_div($sformatf("rnd%0d", i), ra, rb, req, rer, rdz, rovf, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
